// File: rtl/noc_credit_sink.sv
// Terminates a credit-based router output port into a valid/ready stream.
// Flits are buffered in a FIFO; one credit returns per accepted flit, and sticky flags catch protocol errors.
module noc_credit_sink #(
    parameter int unsigned FLIT_WIDTH   = 32,
    parameter int unsigned DEST_WIDTH   = 4,
    parameter int unsigned BUFFER_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [FLIT_WIDTH-1:0]               data_in,
    input  logic [DEST_WIDTH-1:0]               dest_in,
    input  logic                                is_tail_in,
    input  logic                                send_in,
    output logic                                credit_out,
    output logic                                out_tvalid,
    input  logic                                out_tready,
    output logic [FLIT_WIDTH-1:0]               out_tdata,
    output logic [DEST_WIDTH-1:0]               out_tdest,
    output logic                                out_tlast,
    output logic [$clog2(BUFFER_DEPTH):0]       occupancy,
    output logic                                err_overflow,
    output logic                                err_dest
);

    localparam int unsigned PTR_W = $clog2(BUFFER_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    typedef struct packed {
        logic [FLIT_WIDTH-1:0] data;
        logic [DEST_WIDTH-1:0] dest;
        logic                  tail;
    } flit_t;

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } state_t;

    flit_t                 mem [BUFFER_DEPTH];
    flit_t                 in_flit_c;
    flit_t                 head_q;
    flit_t                 head_next_c;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [PTR_W-1:0]      rd_ptr_next_c;
    logic [OCC_W-1:0]      occ_next_c;
    logic                  full_c;
    logic                  pop_c;
    logic                  push_c;
    logic                  overflow_c;
    state_t                state;
    state_t                state_next_c;
    logic [DEST_WIDTH-1:0] pkt_dest;
    logic [DEST_WIDTH-1:0] pkt_dest_next_c;
    logic                  dest_err_c;

    assign in_flit_c  = '{data: data_in, dest: dest_in, tail: is_tail_in};
    assign full_c     = (occupancy == OCC_W'(BUFFER_DEPTH));
    assign pop_c      = out_tvalid && out_tready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_c     = send_in && (!full_c || pop_c);
    assign overflow_c = send_in && full_c && !pop_c;

    assign out_tdata = head_q.data;
    assign out_tdest = head_q.dest;
    assign out_tlast = head_q.tail;

    // Next read pointer, occupancy and head entry; head is registered so out_t* are flop outputs.
    always_comb begin
        rd_ptr_next_c = pop_c ? rd_ptr + PTR_W'(1) : rd_ptr;
        occ_next_c    = occupancy;
        if (push_c && !pop_c) begin
            occ_next_c = occupancy + OCC_W'(1);
        end else if (pop_c && !push_c) begin
            occ_next_c = occupancy - OCC_W'(1);
        end
        if (push_c && (rd_ptr_next_c == wr_ptr)) begin
            head_next_c = in_flit_c;
        end else begin
            head_next_c = mem[rd_ptr_next_c];
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) begin
            mem[wr_ptr] <= in_flit_c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            occupancy    <= '0;
            head_q       <= '0;
            out_tvalid   <= 1'b0;
            credit_out   <= 1'b0;
            err_overflow <= 1'b0;
            err_dest     <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr     <= rd_ptr_next_c;
            occupancy  <= occ_next_c;
            head_q     <= head_next_c;
            out_tvalid <= (occ_next_c != '0);
            credit_out <= pop_c;
            if (overflow_c) begin
                err_overflow <= 1'b1;
            end
            if (dest_err_c) begin
                err_dest <= 1'b1;
            end
        end
    end

    // Packet tracking state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            pkt_dest <= '0;
        end else begin
            state    <= state_next_c;
            pkt_dest <= pkt_dest_next_c;
        end
    end

    // Packet FSM advances only on accepted pushes; dropped flits are ignored.
    always_comb begin
        state_next_c    = state;
        pkt_dest_next_c = pkt_dest;
        dest_err_c      = 1'b0;
        if (push_c) begin
            case (state)
                IDLE: begin
                    if (!is_tail_in) begin
                        pkt_dest_next_c = dest_in;
                        state_next_c    = IN_PKT;
                    end
                end
                IN_PKT: begin
                    if (dest_in != pkt_dest) begin
                        dest_err_c = 1'b1;
                    end
                    if (is_tail_in) begin
                        state_next_c = IDLE;
                    end
                end
                default: state_next_c = IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_noc_credit_sink.sv
// Directed bench for noc_credit_sink: single flit, backpressure, overflow,
// full push+pop, dest checking and mid-packet reset.
module tb_noc_credit_sink;

    localparam int unsigned FW = 32;
    localparam int unsigned DW = 4;
    localparam int unsigned DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] data_in;
    logic [DW-1:0] dest_in;
    logic          is_tail_in;
    logic          send_in;
    logic          credit_out;
    logic          out_tvalid;
    logic          out_tready;
    logic [FW-1:0] out_tdata;
    logic [DW-1:0] out_tdest;
    logic          out_tlast;
    logic [2:0]    occupancy;
    logic          err_overflow;
    logic          err_dest;

    int vecs = 0;
    int miscompares = 0;

    noc_credit_sink #(
        .FLIT_WIDTH  (FW),
        .DEST_WIDTH  (DW),
        .BUFFER_DEPTH(DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .data_in     (data_in),
        .dest_in     (dest_in),
        .is_tail_in  (is_tail_in),
        .send_in     (send_in),
        .credit_out  (credit_out),
        .out_tvalid  (out_tvalid),
        .out_tready  (out_tready),
        .out_tdata   (out_tdata),
        .out_tdest   (out_tdest),
        .out_tlast   (out_tlast),
        .occupancy   (occupancy),
        .err_overflow(err_overflow),
        .err_dest    (err_dest)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [FW-1:0] d, input logic [DW-1:0] de, input logic t);
        send_in    = 1'b1;
        data_in    = d;
        dest_in    = de;
        is_tail_in = t;
        step();
        send_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [FW-1:0] exp4 [4];
        rst        = 1'b1;
        data_in    = '0;
        dest_in    = '0;
        is_tail_in = 1'b0;
        send_in    = 1'b0;
        out_tready = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_tvalid", 64'(out_tvalid), 64'h0);
        chk("rst_occ", 64'(occupancy), 64'h0);
        chk("rst_credit", 64'(credit_out), 64'h0);
        chk("rst_errs", 64'({err_overflow, err_dest}), 64'h0);
        chk("rst_tdata", 64'(out_tdata), 64'h0);

        // T1 single flit
        out_tready = 1'b1;
        chk("t1_no_bypass", 64'(out_tvalid), 64'h0);
        send(32'hDEADBEEF, 4'h5, 1'b1);
        chk("t1_tvalid", 64'(out_tvalid), 64'h1);
        chk("t1_tdata", 64'(out_tdata), 64'hDEADBEEF);
        chk("t1_tdest", 64'(out_tdest), 64'h5);
        chk("t1_tlast", 64'(out_tlast), 64'h1);
        chk("t1_credit_pre", 64'(credit_out), 64'h0);
        step();
        chk("t1_credit", 64'(credit_out), 64'h1);
        chk("t1_empty", 64'(out_tvalid), 64'h0);
        step();
        chk("t1_credit_once", 64'(credit_out), 64'h0);

        // T2 fill under backpressure then drain
        out_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send(FW'(i), 4'h0, 1'b1);
        chk("t2_occ", 64'(occupancy), 64'h4);
        chk("t2_tdata", 64'(out_tdata), 64'h1);
        chk("t2_noerr", 64'(err_overflow), 64'h0);
        step();
        step();
        chk("t2_hold_tdata", 64'(out_tdata), 64'h1);
        chk("t2_hold_tvalid", 64'(out_tvalid), 64'h1);
        chk("t2_no_credit", 64'(credit_out), 64'h0);
        out_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t2_drain_data", 64'(out_tdata), 64'(i));
            step();
            chk("t2_drain_credit", 64'(credit_out), 64'h1);
        end
        chk("t2_drained", 64'(out_tvalid), 64'h0);
        step();
        chk("t2_credit_end", 64'(credit_out), 64'h0);

        // T3 overflow
        out_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send(FW'(i), 4'h0, 1'b1);
        send(32'h5, 4'h0, 1'b1);
        chk("t3_err_ov", 64'(err_overflow), 64'h1);
        chk("t3_occ", 64'(occupancy), 64'h4);
        out_tready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            chk("t3_drain_data", 64'(out_tdata), 64'(i));
            step();
        end
        chk("t3_no_fifth", 64'(out_tvalid), 64'h0);
        chk("t3_sticky", 64'(err_overflow), 64'h1);

        // T4 full with simultaneous push and pop
        do_reset();
        chk("t4_rst_err", 64'(err_overflow), 64'h0);
        out_tready = 1'b0;
        for (int i = 1; i <= 4; i++) send(FW'(i), 4'h0, 1'b1);
        out_tready = 1'b1;
        chk("t4_head", 64'(out_tdata), 64'h1);
        send(32'h10, 4'h0, 1'b1);
        chk("t4_occ", 64'(occupancy), 64'h4);
        chk("t4_no_err", 64'(err_overflow), 64'h0);
        exp4[0] = 32'h2;
        exp4[1] = 32'h3;
        exp4[2] = 32'h4;
        exp4[3] = 32'h10;
        for (int i = 0; i < 4; i++) begin
            chk("t4_drain_data", 64'(out_tdata), 64'(exp4[i]));
            step();
            chk("t4_credit", 64'(credit_out), 64'h1);
        end
        chk("t4_drained", 64'(out_tvalid), 64'h0);

        // T5 dest check
        do_reset();
        out_tready = 1'b1;
        send(32'h20, 4'h2, 1'b0);
        send(32'h21, 4'h2, 1'b0);
        send(32'h22, 4'h2, 1'b1);
        send(32'h70, 4'h7, 1'b1);
        chk("t5_clean", 64'(err_dest), 64'h0);
        send(32'h31, 4'h1, 1'b0);
        chk("t5_first_ok", 64'(err_dest), 64'h0);
        send(32'h32, 4'h3, 1'b0);
        chk("t5_err_dest", 64'(err_dest), 64'h1);
        chk("t5_bad_delivered", 64'(out_tdata), 64'h32);
        chk("t5_bad_dest", 64'(out_tdest), 64'h3);
        send(32'h33, 4'h1, 1'b1);
        chk("t5_tail_data", 64'(out_tdata), 64'h33);
        chk("t5_tail_last", 64'(out_tlast), 64'h1);
        step();
        chk("t5_sticky", 64'(err_dest), 64'h1);

        // T6 reset mid-packet
        do_reset();
        out_tready = 1'b0;
        send(32'hA1, 4'h4, 1'b0);
        send(32'hA2, 4'h4, 1'b0);
        chk("t6_occ_pre", 64'(occupancy), 64'h2);
        do_reset();
        chk("t6_tvalid", 64'(out_tvalid), 64'h0);
        chk("t6_occ", 64'(occupancy), 64'h0);
        chk("t6_credit", 64'(credit_out), 64'h0);
        chk("t6_flags", 64'({err_overflow, err_dest}), 64'h0);
        chk("t6_tdata", 64'(out_tdata), 64'h0);
        step();
        chk("t6_credit_after", 64'(credit_out), 64'h0);
        out_tready = 1'b1;
        send(32'hB1, 4'h9, 1'b0);
        send(32'hB2, 4'h9, 1'b1);
        chk("t6_new_pkt_ok", 64'(err_dest), 64'h0);
        chk("t6_new_data", 64'(out_tdata), 64'hB2);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
